instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC sequencing, branch-target table and counters for a
// synchronous instruction ROM. Run control is a three-state IDLE/RUN/DONE FSM.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  progLen,
  input  logic        stall,
  input  logic        branchEnable,
  input  logic [4:0]  LUTIndex,
  input  logic        lutWe,
  input  logic [4:0]  lutWaddr,
  input  logic [9:0]  lutWdata,
  input  logic [8:0]  imemData,
  output logic [9:0]  imemAddr,
  output logic [8:0]  instr,
  output logic        instrValid,
  output logic [9:0]  pc,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycleCount,
  output logic [15:0] retireCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  lut [32];
  logic [10:0] next_pc;
  logic        advance;
  logic        run_end;
  logic        start_any;
  logic        start_run;

  // next_pc is one bit wider than pc so a target or pc+1 past the end of the
  // address space still compares correctly against progLen.
  assign next_pc   = branchEnable ? {1'b0, lut[LUTIndex]} : ({1'b0, pc} + 11'd1);
  assign advance   = (state == RUN) && !stall;
  assign run_end   = advance && (next_pc >= {1'b0, progLen});
  assign start_any = (state != RUN) && start;
  assign start_run = start_any && (progLen != 10'd0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (progLen != 10'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (run_end) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs. instrValid marks instr as meaningful for every RUN cycle; the
  // decoder consumes it only when stall=0, and a stalled cycle re-presents
  // the same pc/instr pair because the ROM is re-addressed with pc.
  always_comb begin
    imemAddr   = 10'd0;
    busy       = 1'b0;
    done       = 1'b0;
    instrValid = 1'b0;
    case (state)
      RUN: begin
        busy       = 1'b1;
        instrValid = 1'b1;
        imemAddr   = stall ? pc : next_pc[9:0];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign instr = imemData;

  // Program counter: holds on the final instruction when the run ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= 10'd0;
    end else if (start_run) begin
      pc <= 10'd0;
    end else if (advance && !run_end) begin
      pc <= next_pc[9:0];
    end
  end

  // Saturating run counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCount  <= 16'd0;
      retireCount <= 16'd0;
    end else if (start_any) begin
      cycleCount  <= 16'd0;
      retireCount <= 16'd0;
    end else if (state == RUN) begin
      if (cycleCount != 16'hFFFF) begin
        cycleCount <= cycleCount + 16'd1;
      end
      if (!stall && (retireCount != 16'hFFFF)) begin
        retireCount <= retireCount + 16'd1;
      end
    end
  end

  // Branch-target table; a same-cycle read sees the pre-write value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        lut[i] <= 10'd0;
      end
    end else if (lutWe) begin
      lut[lutWaddr] <= lutWdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a synchronous ROM model feeds imemData,
// each scenario task drives its vectors and checks hand-computed responses.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  progLen;
  logic        stall;
  logic        branchEnable;
  logic [4:0]  LUTIndex;
  logic        lutWe;
  logic [4:0]  lutWaddr;
  logic [9:0]  lutWdata;
  logic [8:0]  imemData;
  logic [9:0]  imemAddr;
  logic [8:0]  instr;
  logic        instrValid;
  logic [9:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] cycleCount;
  logic [15:0] retireCount;

  int num_tests;
  int num_fail;

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start), .progLen(progLen),
    .stall(stall), .branchEnable(branchEnable), .LUTIndex(LUTIndex),
    .lutWe(lutWe), .lutWaddr(lutWaddr), .lutWdata(lutWdata),
    .imemData(imemData), .imemAddr(imemAddr), .instr(instr),
    .instrValid(instrValid), .pc(pc), .busy(busy), .done(done),
    .cycleCount(cycleCount), .retireCount(retireCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] rom_word(input logic [9:0] a);
    return 9'((32'(a) * 7 + 3) % 512);
  endfunction

  // synchronous ROM: data valid one cycle after the address
  always @(posedge clk) imemData <= rom_word(imemAddr);

  // driver tasks
  task automatic do_start(input logic [9:0] len);
    @(negedge clk);
    progLen = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [9:0] val);
    @(negedge clk);
    lutWe = 1'b1; lutWaddr = idx; lutWdata = val;
    @(negedge clk);
    lutWe = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    num_tests++; if (busy !== 1'b0) begin num_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    num_tests++; if (done !== 1'b0) begin num_fail++; $display("FAIL reset_done got %b exp 0", done); end
    num_tests++; if (instrValid !== 1'b0) begin num_fail++; $display("FAIL reset_valid got %b exp 0", instrValid); end
    num_tests++; if (imemAddr !== 10'd0) begin num_fail++; $display("FAIL reset_addr got %0d exp 0", imemAddr); end
    num_tests++; if (pc !== 10'd0) begin num_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
    num_tests++; if (cycleCount !== 16'd0 || retireCount !== 16'd0) begin num_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", cycleCount, retireCount); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    num_tests++; if (busy !== 1'b0 || done !== 1'b0) begin num_fail++; $display("FAIL idle_hold got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_straight_line;
    @(negedge clk);
    progLen = 10'd4;
    start   = 1'b1;
    @(negedge clk);
    // start stays high through the first RUN cycle and must be ignored
    for (int i = 0; i < 4; i++) begin
      #1;
      num_tests++; if (pc !== 10'(i) || busy !== 1'b1 || instrValid !== 1'b1) begin num_fail++; $display("FAIL straight_pc%0d got pc=%0d busy=%b valid=%b exp %0d/1/1", i, pc, busy, instrValid, i); end
      num_tests++; if (instr !== rom_word(10'(i))) begin num_fail++; $display("FAIL straight_instr%0d got %0d exp %0d", i, instr, rom_word(10'(i))); end
      num_tests++; if (imemAddr !== 10'(i + 1)) begin num_fail++; $display("FAIL straight_addr%0d got %0d exp %0d", i, imemAddr, i + 1); end
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    num_tests++; if (done !== 1'b1 || busy !== 1'b0 || instrValid !== 1'b0) begin num_fail++; $display("FAIL straight_done got done=%b busy=%b valid=%b exp 1/0/0", done, busy, instrValid); end
    num_tests++; if (cycleCount !== 16'd4 || retireCount !== 16'd4) begin num_fail++; $display("FAIL straight_counts got %0d/%0d exp 4/4", cycleCount, retireCount); end
    num_tests++; if (pc !== 10'd3 || imemAddr !== 10'd0) begin num_fail++; $display("FAIL straight_final got pc=%0d addr=%0d exp 3/0", pc, imemAddr); end
  endtask

  task automatic test_branch;
    lut_write(5'd3, 10'd7);
    do_start(10'd9);
    @(negedge clk);
    @(negedge clk);
    branchEnable = 1'b1; LUTIndex = 5'd3;
    #1;
    num_tests++; if (pc !== 10'd2 || imemAddr !== 10'd7) begin num_fail++; $display("FAIL branch_addr got pc=%0d addr=%0d exp 2/7", pc, imemAddr); end
    @(negedge clk);
    branchEnable = 1'b0;
    #1;
    num_tests++; if (pc !== 10'd7 || instr !== rom_word(10'd7)) begin num_fail++; $display("FAIL branch_target got pc=%0d instr=%0d exp 7/%0d", pc, instr, rom_word(10'd7)); end
    @(negedge clk);
    #1;
    num_tests++; if (pc !== 10'd8 || busy !== 1'b1) begin num_fail++; $display("FAIL branch_follow got pc=%0d busy=%b exp 8/1", pc, busy); end
    @(negedge clk);
    #1;
    num_tests++; if (done !== 1'b1 || pc !== 10'd8) begin num_fail++; $display("FAIL branch_done got done=%b pc=%0d exp 1/8", done, pc); end
    num_tests++; if (cycleCount !== 16'd5 || retireCount !== 16'd5) begin num_fail++; $display("FAIL branch_counts got %0d/%0d exp 5/5", cycleCount, retireCount); end
  endtask

  task automatic test_stall;
    do_start(10'd4);
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      num_tests++; if (pc !== 10'd1 || imemAddr !== 10'd1 || instr !== rom_word(10'd1)) begin num_fail++; $display("FAIL stall_hold%0d got pc=%0d addr=%0d instr=%0d exp 1/1/%0d", i, pc, imemAddr, instr, rom_word(10'd1)); end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    num_tests++; if (pc !== 10'd1 || imemAddr !== 10'd2) begin num_fail++; $display("FAIL stall_release got pc=%0d addr=%0d exp 1/2", pc, imemAddr); end
    repeat (3) @(negedge clk);
    #1;
    num_tests++; if (done !== 1'b1) begin num_fail++; $display("FAIL stall_done got %b exp 1", done); end
    num_tests++; if (cycleCount !== 16'd7 || retireCount !== 16'd4) begin num_fail++; $display("FAIL stall_counts got %0d/%0d exp 7/4", cycleCount, retireCount); end
  endtask

  task automatic test_boundary;
    lut_write(5'd9, 10'd20);
    do_start(10'd9);
    @(negedge clk);
    branchEnable = 1'b1; LUTIndex = 5'd9;
    #1;
    num_tests++; if (imemAddr !== 10'd20) begin num_fail++; $display("FAIL boundary_addr got %0d exp 20", imemAddr); end
    @(negedge clk);
    #1;
    num_tests++; if (done !== 1'b1 || pc !== 10'd1) begin num_fail++; $display("FAIL boundary_done got done=%b pc=%0d exp 1/1", done, pc); end
    num_tests++; if (cycleCount !== 16'd2 || retireCount !== 16'd2) begin num_fail++; $display("FAIL boundary_counts got %0d/%0d exp 2/2", cycleCount, retireCount); end
    // branch inputs still asserted in DONE must not move the ROM address
    num_tests++; if (imemAddr !== 10'd0) begin num_fail++; $display("FAIL done_addr got %0d exp 0", imemAddr); end
    branchEnable = 1'b0;
    do_start(10'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      num_tests++; if (busy !== 1'b0 || done !== 1'b1) begin num_fail++; $display("FAIL zero_len%0d got busy=%b done=%b exp 0/1", i, busy, done); end
      @(negedge clk);
    end
    num_tests++; if (cycleCount !== 16'd0 || retireCount !== 16'd0) begin num_fail++; $display("FAIL zero_len_counts got %0d/%0d exp 0/0", cycleCount, retireCount); end
  endtask

  task automatic test_lut_collision;
    int n;
    lut_write(5'd5, 10'd4);
    do_start(10'd20);
    branchEnable = 1'b1; LUTIndex = 5'd5;
    lutWe = 1'b1; lutWaddr = 5'd5; lutWdata = 10'd12;
    #1;
    num_tests++; if (imemAddr !== 10'd4) begin num_fail++; $display("FAIL collide_addr got %0d exp 4", imemAddr); end
    @(negedge clk);
    lutWe = 1'b0;
    #1;
    num_tests++; if (pc !== 10'd4 || imemAddr !== 10'd12) begin num_fail++; $display("FAIL collide_next got pc=%0d addr=%0d exp 4/12", pc, imemAddr); end
    @(negedge clk);
    branchEnable = 1'b0;
    #1;
    num_tests++; if (pc !== 10'd12) begin num_fail++; $display("FAIL collide_new got pc=%0d exp 12", pc); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    num_tests++; if (done !== 1'b1) begin num_fail++; $display("FAIL collide_timeout got done=%b exp 1", done); end
    num_tests++; if (pc !== 10'd19 || retireCount !== 16'd10) begin num_fail++; $display("FAIL collide_final got pc=%0d retire=%0d exp 19/10", pc, retireCount); end
  endtask

  task automatic test_reset_mid_run;
    int n;
    do_start(10'd9);
    repeat (2) @(negedge clk);
    #1;
    num_tests++; if (pc !== 10'd2 || busy !== 1'b1) begin num_fail++; $display("FAIL midrun_pre got pc=%0d busy=%b exp 2/1", pc, busy); end
    reset_n = 1'b0;
    #1;
    num_tests++; if (busy !== 1'b0 || pc !== 10'd0 || instrValid !== 1'b0 || imemAddr !== 10'd0) begin num_fail++; $display("FAIL midrun_abort got busy=%b pc=%0d valid=%b addr=%0d exp 0/0/0/0", busy, pc, instrValid, imemAddr); end
    num_tests++; if (cycleCount !== 16'd0 || retireCount !== 16'd0) begin num_fail++; $display("FAIL midrun_counts got %0d/%0d exp 0/0", cycleCount, retireCount); end
    @(negedge clk);
    reset_n = 1'b1;
    branchEnable = 1'b1; LUTIndex = 5'd3;
    do_start(10'd9);
    #1;
    // lut[3] held 7 before reset and must now read 0
    num_tests++; if (pc !== 10'd0 || busy !== 1'b1 || imemAddr !== 10'd0) begin num_fail++; $display("FAIL restart_lut got pc=%0d busy=%b addr=%0d exp 0/1/0", pc, busy, imemAddr); end
    @(negedge clk);
    branchEnable = 1'b0;
    #1;
    num_tests++; if (pc !== 10'd0 || imemAddr !== 10'd1) begin num_fail++; $display("FAIL restart_pc got pc=%0d addr=%0d exp 0/1", pc, imemAddr); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    num_tests++; if (done !== 1'b1 || pc !== 10'd8 || cycleCount !== 16'd10) begin num_fail++; $display("FAIL restart_done got done=%b pc=%0d cycles=%0d exp 1/8/10", done, pc, cycleCount); end
  endtask

  initial begin
    num_tests = 0;
    num_fail  = 0;
    start = 1'b0; progLen = 10'd0; stall = 1'b0; branchEnable = 1'b0;
    LUTIndex = 5'd0; lutWe = 1'b0; lutWaddr = 5'd0; lutWdata = 10'd0;
    test_reset;
    test_straight_line;
    test_branch;
    test_stall;
    test_boundary;
    test_lut_collision;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

endmodule
